// File: rtl/pong_match_ctrl.sv
// rtl/pong_match_ctrl.sv - pong match controller: paddle/ball kinematics, scoring and match FSM
module pong_match_ctrl #(
  parameter int H_RES        = 640,
  parameter int V_RES        = 480,
  parameter int X_W          = 10,
  parameter int Y_W          = 10,
  parameter int BORDER       = 10,
  parameter int PADDLE_W     = 10,
  parameter int PADDLE_H     = 60,
  parameter int BALL_SIDE    = 8,
  parameter int PLAYER_X     = 620,
  parameter int PC_X         = 20,
  parameter int PLAYER_SPEED = 4,
  parameter int PC_SPEED     = 3,
  parameter int SERVE_SPEED  = 2,
  parameter int MAX_SPEED    = 7,
  parameter int V_W          = 5,
  parameter int SERVE_FRAMES = 60,
  parameter int WIN_SCORE    = 5,
  parameter int SCORE_W      = 3
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               new_frame_i,
  input  logic [2:0]         keys_i,
  input  logic [1:0]         rnd_i,
  output logic [Y_W-1:0]     player_paddle_y_o,
  output logic [Y_W-1:0]     pc_paddle_y_o,
  output logic [X_W-1:0]     ball_x_o,
  output logic [Y_W-1:0]     ball_y_o,
  output logic [SCORE_W-1:0] score_player_o,
  output logic [SCORE_W-1:0] score_pc_o,
  output logic [2:0]         state_o,
  output logic               winner_o
);

  localparam int CNT_W = $clog2(SERVE_FRAMES);

  localparam logic [Y_W-1:0]         PAD_LO    = Y_W'(BORDER);
  localparam logic [Y_W-1:0]         PAD_HI    = Y_W'(V_RES - BORDER - PADDLE_H);
  localparam logic [Y_W-1:0]         PAD_MID   = Y_W'((V_RES - PADDLE_H) / 2);
  localparam logic [Y_W-1:0]         P_STEP    = Y_W'(PLAYER_SPEED);
  localparam logic [Y_W-1:0]         PH_M1     = Y_W'(PADDLE_H - 1);
  localparam logic [Y_W-1:0]         BSY_M1    = Y_W'(BALL_SIDE - 1);
  localparam logic [X_W-1:0]         BSX_M1    = X_W'(BALL_SIDE - 1);
  localparam logic [X_W-1:0]         PL_X0     = X_W'(PLAYER_X);
  localparam logic [X_W-1:0]         PL_X1     = X_W'(PLAYER_X + PADDLE_W - 1);
  localparam logic [X_W-1:0]         PC_X0     = X_W'(PC_X);
  localparam logic [X_W-1:0]         PC_X1     = X_W'(PC_X + PADDLE_W - 1);
  localparam logic [X_W-1:0]         BALL_CX   = X_W'((H_RES - BALL_SIDE) / 2);
  localparam logic [Y_W-1:0]         BALL_CY   = Y_W'((V_RES - BALL_SIDE) / 2);
  localparam logic [Y_W-1:0]         BALL_YLO  = Y_W'(BORDER);
  localparam logic [Y_W-1:0]         BALL_YHI  = Y_W'(V_RES - BORDER - BALL_SIDE);
  localparam logic signed [X_W:0]    NX_MAX    = (X_W+1)'(H_RES - BALL_SIDE);
  localparam logic signed [Y_W:0]    NY_MIN    = (Y_W+1)'(BORDER);
  localparam logic signed [Y_W:0]    NY_MAX    = (Y_W+1)'(V_RES - BORDER - BALL_SIDE);
  localparam logic signed [Y_W+1:0]  PC_BIAS   = (Y_W+2)'(BALL_SIDE / 2 - PADDLE_H / 2);
  localparam logic signed [Y_W+1:0]  PC_STEP   = (Y_W+2)'(PC_SPEED);
  localparam logic signed [Y_W+1:0]  PAD_LO_S  = (Y_W+2)'(BORDER);
  localparam logic signed [Y_W+1:0]  PAD_HI_S  = (Y_W+2)'(V_RES - BORDER - PADDLE_H);
  localparam logic signed [V_W-1:0]  V_SERVE   = V_W'(SERVE_SPEED);
  localparam logic signed [V_W-1:0]  V_MAX     = V_W'(MAX_SPEED);
  localparam logic signed [V_W-1:0]  V_ONE     = V_W'(1);
  localparam logic [CNT_W-1:0]       CNT_LAST  = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [SCORE_W-1:0]     SCORE_WIN = SCORE_W'(WIN_SCORE);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_POINT = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [Y_W-1:0]        ply_q, ply_d, pcy_q, pcy_d, by_q, by_d;
  logic [X_W-1:0]        bx_q, bx_d;
  logic signed [V_W-1:0] vx_q, vx_d, vy_q, vy_d;
  logic [SCORE_W-1:0]    sp_q, sp_d, spc_q, spc_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  dir_q, dir_d;   // 1 = next serve heads toward the pc (negative vx)
  logic                  win_q, win_d;

  logic [Y_W-1:0]        ply_mv, pc_mv, ball_y1;
  logic [X_W-1:0]        ball_x1;
  logic signed [Y_W+1:0] pc_d, pc_step, pc_tgt;
  logic signed [X_W:0]   nx;
  logic signed [Y_W:0]   ny;
  logic signed [V_W-1:0] vx_mag, vy_mag, vx_bump;
  logic                  y_pl, y_pc, hit_pl, hit_pc;

  always_comb begin
    ply_mv = ply_q;
    if (keys_i[0] && !keys_i[1])
      ply_mv = (ply_q < PAD_LO + P_STEP) ? PAD_LO : ply_q - P_STEP;
    else if (keys_i[1] && !keys_i[0])
      ply_mv = (ply_q + P_STEP > PAD_HI) ? PAD_HI : ply_q + P_STEP;
  end

  assign pc_d    = $signed({2'b00, by_q}) - $signed({2'b00, pcy_q}) + PC_BIAS;
  assign pc_step = (pc_d > PC_STEP) ? PC_STEP : ((pc_d < -PC_STEP) ? -PC_STEP : pc_d);
  assign pc_tgt  = $signed({2'b00, pcy_q}) + pc_step;
  assign pc_mv   = (pc_tgt < PAD_LO_S) ? PAD_LO :
                   ((pc_tgt > PAD_HI_S) ? PAD_HI : pc_tgt[Y_W-1:0]);

  assign nx = $signed({1'b0, bx_q}) + (X_W+1)'(vx_q);
  assign ny = $signed({1'b0, by_q}) + (Y_W+1)'(vy_q);

  assign vx_mag  = vx_q[V_W-1] ? -vx_q : vx_q;
  assign vy_mag  = vy_q[V_W-1] ? -vy_q : vy_q;
  assign vx_bump = (vx_mag >= V_MAX) ? V_MAX : vx_mag + V_ONE;

  // Hits only count when the ball is travelling into the paddle, so it cannot stick.
  assign ball_x1 = bx_q + BSX_M1;
  assign ball_y1 = by_q + BSY_M1;
  assign y_pl    = (by_q <= ply_q + PH_M1) && (ball_y1 >= ply_q);
  assign y_pc    = (by_q <= pcy_q + PH_M1) && (ball_y1 >= pcy_q);
  assign hit_pl  = y_pl && (bx_q <= PL_X1) && (ball_x1 >= PL_X0) && !vx_q[V_W-1] && (vx_q != '0);
  assign hit_pc  = y_pc && (bx_q <= PC_X1) && (ball_x1 >= PC_X0) && vx_q[V_W-1];

  always_comb begin
    state_d = state_q;
    ply_d   = ply_q;
    pcy_d   = pcy_q;
    bx_d    = bx_q;
    by_d    = by_q;
    vx_d    = vx_q;
    vy_d    = vy_q;
    sp_d    = sp_q;
    spc_d   = spc_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    win_d   = win_q;
    if (new_frame_i) begin
      if (state_q != S_OVER) ply_d = ply_mv;
      case (state_q)
        S_IDLE: begin
          if (keys_i[2]) begin
            state_d = S_SERVE;
            sp_d    = '0;
            spc_d   = '0;
            cnt_d   = '0;
            dir_d   = rnd_i[0];
          end
        end
        S_SERVE: begin
          if (cnt_q == CNT_LAST) begin
            vx_d    = dir_q ? -V_SERVE : V_SERVE;
            vy_d    = rnd_i[1] ? -V_SERVE : V_SERVE;
            cnt_d   = '0;
            state_d = S_PLAY;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_PLAY: begin
          pcy_d = pc_mv;
          if (nx[X_W] || (nx > NX_MAX)) begin
            if (nx[X_W]) begin
              sp_d  = sp_q + 1'b1;
              dir_d = 1'b1;
            end else begin
              spc_d = spc_q + 1'b1;
              dir_d = 1'b0;
            end
            bx_d    = BALL_CX;
            by_d    = BALL_CY;
            vx_d    = '0;
            vy_d    = '0;
            state_d = S_POINT;
          end else begin
            if (ny < NY_MIN) begin
              by_d = BALL_YLO;
              vy_d = vy_mag;
            end else if (ny > NY_MAX) begin
              by_d = BALL_YHI;
              vy_d = -vy_mag;
            end else begin
              by_d = ny[Y_W-1:0];
            end
            if (hit_pl || hit_pc) vx_d = vx_q[V_W-1] ? vx_bump : -vx_bump;
            else                  bx_d = nx[X_W-1:0];
          end
        end
        S_POINT: begin
          if ((sp_q == SCORE_WIN) || (spc_q == SCORE_WIN)) begin
            state_d = S_OVER;
            win_d   = (sp_q == SCORE_WIN);
          end else begin
            state_d = S_SERVE;
          end
        end
        S_OVER: begin
          if (keys_i[2]) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      ply_q   <= PAD_MID;
      pcy_q   <= PAD_MID;
      bx_q    <= BALL_CX;
      by_q    <= BALL_CY;
      vx_q    <= '0;
      vy_q    <= '0;
      sp_q    <= '0;
      spc_q   <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      win_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ply_q   <= ply_d;
      pcy_q   <= pcy_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
      vx_q    <= vx_d;
      vy_q    <= vy_d;
      sp_q    <= sp_d;
      spc_q   <= spc_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      win_q   <= win_d;
    end
  end

  assign player_paddle_y_o = ply_q;
  assign pc_paddle_y_o     = pcy_q;
  assign ball_x_o          = bx_q;
  assign ball_y_o          = by_q;
  assign score_player_o    = sp_q;
  assign score_pc_o        = spc_q;
  assign state_o           = state_q;
  assign winner_o          = win_q;

endmodule
